// File: rtl/axi_ahb_master_bridge.sv
// AXI4-Lite slave to AHB-Lite master bridge: one outstanding single transfer,
// alternating write/read grant when both are pending, optional hready timeout.
module axi_ahb_master_bridge #(
   parameter int         TIMEOUT_CYCLES = 256,
   parameter logic [2:0] HBURST_SINGLE  = 3'b000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] awaddr,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] haddr,
   output logic [1:0]  htrans,
   output logic        hwrite,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic [3:0]  hprot,
   output logic [31:0] hwdata,
   input  logic [31:0] hrdata,
   input  logic        hready,
   input  logic        hresp
);
   localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;
   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRESP, RRESP} state_t;
   state_t state, state_nxt;

   logic             prefer_rd;
   logic [CNT_W-1:0] to_cnt;
   logic [1:0]       resp_q;
   logic             wr_pend, rd_pend, wr_grant, rd_grant, to_hit;
   logic [5:0]       strb_dec;

   // Returns {legal, hsize, haddr[1:0]} for a write strobe pattern.
   function automatic logic [5:0] decode_strb(input logic [3:0] strb);
      case (strb)
         4'b1111: decode_strb = {1'b1, 3'b010, 2'b00};
         4'b0011: decode_strb = {1'b1, 3'b001, 2'b00};
         4'b1100: decode_strb = {1'b1, 3'b001, 2'b10};
         4'b0001: decode_strb = {1'b1, 3'b000, 2'b00};
         4'b0010: decode_strb = {1'b1, 3'b000, 2'b01};
         4'b0100: decode_strb = {1'b1, 3'b000, 2'b10};
         4'b1000: decode_strb = {1'b1, 3'b000, 2'b11};
         default: decode_strb = 6'b000000;
      endcase
   endfunction

   assign strb_dec = decode_strb(wstrb);
   assign wr_pend  = reset & awvalid & wvalid;
   assign rd_pend  = reset & arvalid;
   assign wr_grant = wr_pend & (~rd_pend | ~prefer_rd);
   assign rd_grant = rd_pend & (~wr_pend | prefer_rd);
   assign to_hit   = (TIMEOUT_CYCLES > 0) && !hready && (to_cnt == TO_LAST);
   assign hburst   = HBURST_SINGLE;
   assign bresp    = resp_q;
   assign rresp    = resp_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      awready   = 1'b0;
      wready    = 1'b0;
      arready   = 1'b0;
      bvalid    = 1'b0;
      rvalid    = 1'b0;
      htrans    = TRANS_IDLE;
      case (state)
         IDLE: begin
            awready = wr_grant;
            wready  = wr_grant;
            arready = rd_grant;
            if (wr_grant)      state_nxt = strb_dec[5] ? ADDR : WRESP;
            else if (rd_grant) state_nxt = ADDR;
         end
         ADDR: begin
            htrans = TRANS_NONSEQ;
            if (hready)      state_nxt = DATA;
            else if (to_hit) state_nxt = hwrite ? WRESP : RRESP;
         end
         DATA: begin
            if (hready || to_hit) state_nxt = hwrite ? WRESP : RRESP;
         end
         WRESP: begin
            bvalid = 1'b1;
            if (bready) state_nxt = IDLE;
         end
         RRESP: begin
            rvalid = 1'b1;
            if (rready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prefer_rd <= 1'b0;
         to_cnt    <= '0;
         resp_q    <= RESP_OKAY;
         rdata     <= '0;
         haddr     <= '0;
         hwrite    <= 1'b0;
         hsize     <= '0;
         hprot     <= '0;
         hwdata    <= '0;
      end else begin
         // Stall counter restarts whenever the FSM changes state.
         if (state_nxt != state)
            to_cnt <= '0;
         else if ((state == ADDR || state == DATA) && !hready)
            to_cnt <= to_cnt + 1'b1;

         if (state == IDLE && wr_grant) begin
            haddr     <= {awaddr[31:2], strb_dec[1:0]};
            hsize     <= strb_dec[4:2];
            hwrite    <= 1'b1;
            hwdata    <= wdata;
            hprot     <= {2'b00, awprot[0], ~awprot[2]};
            resp_q    <= strb_dec[5] ? RESP_OKAY : RESP_SLVERR;
            prefer_rd <= 1'b1;
         end else if (state == IDLE && rd_grant) begin
            haddr     <= {araddr[31:2], 2'b00};
            hsize     <= 3'b010;
            hwrite    <= 1'b0;
            hprot     <= {2'b00, arprot[0], ~arprot[2]};
            resp_q    <= RESP_OKAY;
            prefer_rd <= 1'b0;
         end else if (state == DATA && hready) begin
            resp_q <= hresp ? RESP_SLVERR : RESP_OKAY;
            if (!hwrite) rdata <= hrdata;
         end else if ((state == ADDR || state == DATA) && to_hit) begin
            resp_q <= RESP_SLVERR;
            if (!hwrite) rdata <= '0;
         end
      end
   end
endmodule

// File: tb/tb_axi_ahb_master_bridge.sv
// Directed bench for axi_ahb_master_bridge with a scripted zero/wait-state AHB slave.
module tb_axi_ahb_master_bridge;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] awaddr, wdata, araddr, rdata, haddr, hwdata, hrdata;
   logic [2:0]  awprot, arprot, hsize, hburst;
   logic [3:0]  wstrb, hprot;
   logic [1:0]  bresp, rresp, htrans;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, hwrite, hready, hresp;

   int n_checks = 0;
   int n_errors = 0;

   axi_ahb_master_bridge #(.TIMEOUT_CYCLES(8), .HBURST_SINGLE(3'b000)) dut (
      .clk(clk), .reset(reset),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready), .hresp(hresp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] prot,
                            input int exp_lat, input int exp_ns, input logic [31:0] exp_haddr,
                            input logic [2:0] exp_hsize, input logic [3:0] exp_hprot,
                            input logic [1:0] exp_bresp);
      int lat, ns;
      logic prev_ns;
      logic [31:0] got_haddr, got_hwdata;
      logic [2:0] got_hsize;
      logic [3:0] got_hprot;
      logic got_hwrite;
      got_haddr = '0; got_hwdata = '0; got_hsize = '0; got_hprot = '0; got_hwrite = 1'b0;
      awaddr = a; wdata = d; wstrb = s; awprot = prot;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; hready = 1'b1; hresp = 1'b0;
      #1;
      chk({tag, "_ready"}, 64'({awready, wready, arready}), 64'(3'b110));
      cyc();
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 1; ns = 0; prev_ns = 1'b0;
      while (!bvalid && lat < 40) begin
         if (prev_ns) got_hwdata = hwdata;
         prev_ns = (htrans == 2'b10);
         if (prev_ns) begin
            ns++;
            got_haddr = haddr; got_hsize = hsize; got_hwrite = hwrite; got_hprot = hprot;
         end
         cyc();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_nonseq"}, 64'(ns), 64'(exp_ns));
      chk({tag, "_bresp"}, 64'(bresp), 64'(exp_bresp));
      if (exp_ns > 0) begin
         chk({tag, "_haddr"}, 64'(got_haddr), 64'(exp_haddr));
         chk({tag, "_hsize"}, 64'(got_hsize), 64'(exp_hsize));
         chk({tag, "_hwrite"}, 64'(got_hwrite), 64'(1'b1));
         chk({tag, "_hprot"}, 64'(got_hprot), 64'(exp_hprot));
         chk({tag, "_hwdata"}, 64'(got_hwdata), 64'(d));
      end
      cyc();
      chk({tag, "_bdone"}, 64'(bvalid), 64'(1'b0));
   endtask

   task automatic axi_read(input string tag, input logic [31:0] a, input int waits,
                           input logic err, input logic noise, input logic stuck,
                           input logic [31:0] val, input int hold,
                           input int exp_lat, input int exp_ns, input logic [31:0] exp_haddr,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_rresp);
      int lat, ns, dp, held;
      logic in_dp;
      logic [31:0] got_haddr, got_rdata;
      logic [1:0] got_rresp;
      got_haddr = '0;
      araddr = a; arprot = 3'b000; arvalid = 1'b1; rready = 1'b0;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'hBAD0_0000;
      #1;
      chk({tag, "_ready"}, 64'({awready, wready, arready}), 64'(3'b001));
      cyc();
      arvalid = 1'b0;
      lat = 1; ns = 0; dp = 0; in_dp = 1'b0;
      while (!rvalid && lat < 40) begin
         if (htrans == 2'b10) begin
            ns++;
            got_haddr = haddr;
            hready = !stuck; hresp = 1'b0;
            in_dp = !stuck;
         end else if (in_dp) begin
            hready = (dp >= waits);
            hresp  = err ? (dp >= waits - 1) : ((dp < waits) ? noise : 1'b0);
            hrdata = (dp >= waits) ? val : 32'hBAD0_0000;
            dp++;
         end
         cyc();
         lat++;
      end
      hready = 1'b1; hresp = 1'b0;
      got_rdata = rdata; got_rresp = rresp;
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_nonseq"}, 64'(ns), 64'(exp_ns));
      chk({tag, "_rdata"}, 64'(got_rdata), 64'(exp_rdata));
      chk({tag, "_rresp"}, 64'(got_rresp), 64'(exp_rresp));
      if (exp_ns > 0) chk({tag, "_haddr"}, 64'(got_haddr), 64'(exp_haddr));
      held = 0;
      for (int k = 0; k < hold; k++) begin
         cyc();
         if (rvalid && rdata == got_rdata && rresp == got_rresp) held++;
      end
      if (hold > 0) chk({tag, "_hold"}, 64'(held), 64'(hold));
      rready = 1'b1;
      cyc();
      chk({tag, "_rdone"}, 64'(rvalid), 64'(1'b0));
      rready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_handshake"}, 64'({awready, wready, arready, bvalid, rvalid}), 64'(0));
      chk({tag, "_resp"}, 64'({bresp, rresp}), 64'(0));
      chk({tag, "_rdata"}, 64'(rdata), 64'(0));
      chk({tag, "_haddr"}, 64'(haddr), 64'(0));
      chk({tag, "_htrans"}, 64'(htrans), 64'(0));
      chk({tag, "_ctrl"}, 64'({hwrite, hsize, hburst, hprot}), 64'(0));
      chk({tag, "_hwdata"}, 64'(hwdata), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seq, ng, ov, guard, stray;
      logic busy, hs_w, hs_r;
      reset = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; awprot = '0; araddr = '0; arprot = '0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      hrdata = '0; hready = 1'b1; hresp = 1'b0;
      #3;
      check_reset_outputs("por");
      cyc(); cyc();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      reset = 1'b1;
      cyc();

      axi_write("w_word", 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 3'b000,
                3, 1, 32'h1000_0004, 3'b010, 4'b0001, 2'b00);
      axi_write("w_half", 32'h0000_0020, 32'h55AA_1234, 4'b1100, 3'b101,
                3, 1, 32'h0000_0022, 3'b001, 4'b0010, 2'b00);
      axi_write("w_badstrb", 32'h0000_0020, 32'h1111_2222, 4'b0101, 3'b000,
                1, 0, 32'h0, 3'b000, 4'b0000, 2'b10);
      axi_write("w_byte", 32'h0000_1000, 32'h0000_A500, 4'b0010, 3'b100,
                3, 1, 32'h0000_1001, 3'b000, 4'b0000, 2'b00);
      axi_write("w_nostrb", 32'h0000_0030, 32'h3333_4444, 4'b0000, 3'b000,
                1, 0, 32'h0, 3'b000, 4'b0000, 2'b10);

      axi_read("r_wait3", 32'h0000_3003, 3, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 5,
               6, 1, 32'h0000_3000, 32'h1234_5678, 2'b00);
      axi_read("r_err", 32'h0000_0044, 1, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 0,
               4, 1, 32'h0000_0044, 32'hCAFE_F00D, 2'b10);
      axi_read("r_timeout", 32'h0000_0083, 0, 1'b0, 1'b0, 1'b1, 32'h7777_7777, 0,
               9, 8, 32'h0000_0080, 32'h0000_0000, 2'b10);

      // Reset while the write sits in its data phase.
      awaddr = 32'h0000_0050; wdata = 32'h0BAD_CAFE; wstrb = 4'b1111; awprot = 3'b011;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; hready = 1'b1;
      cyc();
      awvalid = 1'b0; wvalid = 1'b0;
      cyc();
      hready = 1'b0;
      #1;
      chk("mid_hwdata", 64'(hwdata), 64'(32'h0BAD_CAFE));
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      cyc(); cyc();
      reset = 1'b1; hready = 1'b1;
      stray = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (bvalid || rvalid || htrans != 2'b00) stray++;
      end
      chk("post_rst_quiet", 64'(stray), 64'(0));

      // Simultaneous write and read requests, four rounds.
      awaddr = 32'h0000_0100; wdata = 32'hA5A5_5A5A; wstrb = 4'b1111; awprot = 3'b000;
      araddr = 32'h0000_0200; arprot = 3'b000;
      bready = 1'b1; rready = 1'b1; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      seq = 0; ng = 0; ov = 0; busy = 1'b0;
      for (int r = 0; r < 4; r++) begin
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; guard = 0;
         while ((awvalid || arvalid) && guard < 40) begin
            #1;
            hs_w = awready & wready;
            hs_r = arready;
            if ((bvalid && bready) || (rvalid && rready)) busy = 1'b0;
            if (hs_w || hs_r) begin
               if (busy || (hs_w && hs_r)) ov++;
               busy = 1'b1;
               ng++;
               seq = ((seq << 1) | int'(hs_w)) & 8'hFF;
            end
            cyc();
            if (hs_w) begin awvalid = 1'b0; wvalid = 1'b0; end
            if (hs_r) arvalid = 1'b0;
            guard++;
         end
      end
      for (int k = 0; k < 6; k++) cyc();
      chk("arb_count", 64'(ng), 64'(8));
      chk("arb_order", 64'(seq), 64'(8'hAA));
      chk("arb_overlap", 64'(ov), 64'(0));
      chk("arb_drained", 64'({bvalid, rvalid}), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
